alu_imm_sequencer: RTL
======================

Name: alu_imm_sequencer

Overview:
Control-step sequencer that drives the datapath control lines for immediate-format ALU instructions (addi, andi, ori): fetch (T0–T2), then execute (T3–T5).
- Generalises the fixed andi T0–T5 sequence:
  - opcode decode selects the ALU operation;
  - start/busy/done handshake;
  - memory-ready wait states with a timeout;
  - illegal-opcode abort.
- Sits between the top-level control and the datapath; the datapath's Grb/Gra/Cout logic extracts register fields and the immediate from IR.

Parameters:
IR_W, 32, instruction register width
OPC_W, 5, opcode field width; opcode = ir[IR_W-1 -: OPC_W]
TIMEOUT, 15, max cycles spent waiting for mem_ready before error (1..255)
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
Clock  in  1  system clock, all state updates on rising edge
Clear  in  1  synchronous active-low reset
start  in  1  request to execute one instruction; sampled only in IDLE
ir  in  IR_W  current IR contents from datapath
mem_ready  in  1  memory read data valid
PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Gra, Grb, Rin, Rout, Cout  out  1 each  datapath controls
alu_op  out  3  one-hot ALU select: [0]=ADD, [1]=AND, [2]=OR
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in T5
illegal  out  1  one-cycle pulse: unsupported opcode detected in T3
timeout_err  out  1  one-cycle pulse: memory wait exceeded TIMEOUT
state  out  4  current state encoding (debug)

Behaviour:
- Moore FSM. Every output decodes from the registered state (plus the latched opcode for alu_op). Outputs are valid for the entire cycle the state is held.
- Clear low at a rising edge: state <= IDLE, opcode latch <= 0, wait counter <= 0. All outputs read 0 in the following cycle. This applies from any state, including mid-instruction.
- Encodings: IDLE=0, T0=1, T1=2, T1W=3, T2=4, T3=5, T4=6, T5=7.
- IDLE: no controls asserted. start=1 -> T0; otherwise stay. start in any other state is ignored.
- T0: PCout, MARin, IncPC, Zin. -> T1.
- T1: Zlowout, PCin, Read, MDRin.
  - mem_ready=1 -> T2.
  - mem_ready=0 -> T1W, wait counter <= 1.
- T1W: Read and MDRin only. PCin and Zlowout are NOT repeated.
  - mem_ready=1 -> T2.
  - Otherwise, counter == TIMEOUT -> IDLE with timeout_err=1 during this cycle.
  - Otherwise counter++ and stay.
- T2: MDRout, IRin. IR captures the instruction at the end of T2. -> T3.
- T3: decode ir opcode. Supported opcodes are 01011 addi, 01100 andi, 01101 ori.
  - Supported: Grb, Rout, Yin; latch the decoded one-hot op -> T4.
  - Unsupported: illegal=1 and no datapath controls asserted -> IDLE.
- T4: Cout, Zin; alu_op = latched op. alu_op is 0 in every other state. -> T5.
- T5: Zlowout, Gra, Rin, done=1 -> IDLE. No back-to-back start; start is re-sampled in IDLE.
- Latency with zero wait states: start high at edge n -> T0 in cycle n+1 -> T5 (done) in cycle n+6 -> IDLE at n+7. Each T1W cycle adds one cycle.
- The latched opcode shields T4 from ir changes after T3.
- Never assert Read and Zin simultaneously. Never assert two bus drivers (PCout, Zlowout, MDRout, Rout, Cout) in the same cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding constants;
  - opcode constants (OPC_ADDI, OPC_ANDI, OPC_ORI);
  - alu_op bit indices (ALU_ADD=0, ALU_AND=1, ALU_OR=2).
- One combinational sub-module, imm_op_decode: input opcode[OPC_W-1:0]; outputs alu_onehot[2:0] and legal. It is reused later by the register-format sequencer.

Test Plan:
- Reset then andi: ir=0x6108001A, mem_ready tied 1, start pulse at edge n -> state sequence T0..T5 in cycles n+1..n+6. alu_op=3'b010 only in T4. done high only at n+6. busy low at n+7.
- addi 0x5908001A and ori 0x6908001A -> alu_op=3'b001 and 3'b100 respectively in T4. All other controls identical to the andi case.
- Memory wait: mem_ready low for 3 cycles after entering T1 -> one T1 cycle then 3 T1W cycles with Read=MDRin=1, PCin=0. T2 entered on the cycle after mem_ready rises. done at n+9.
- Timeout: mem_ready held 0 -> timeout_err pulses after TIMEOUT cycles in T1W, state returns to IDLE, done never asserts, IRin never asserts.
- Illegal: ir opcode 00000 -> illegal pulses in T3, Grb/Rout/Yin stay 0, IDLE next cycle, no T4/T5.
- Reset mid-op: Clear low during T4 -> next cycle state=IDLE and every output 0. A fresh start then completes a normal andi sequence.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the immediate-format ALU control sequencer:
// state encodings, supported opcodes, alu_op one-hot bit positions and the
// packed datapath control word.
package ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OPC_BITS = 5;
    localparam int unsigned ALU_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1W  = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7
    } state_t;

    localparam logic [OPC_BITS-1:0] OPC_ADDI = 5'b01011;
    localparam logic [OPC_BITS-1:0] OPC_ANDI = 5'b01100;
    localparam logic [OPC_BITS-1:0] OPC_ORI  = 5'b01101;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_AND = 1;
    localparam int unsigned ALU_OR  = 2;

    // One bit per datapath control line
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic inc_pc;
        logic read;
        logic gra;
        logic grb;
        logic r_in;
        logic r_out;
        logic c_out;
    } dp_ctrl_t;

endpackage

// File: rtl/alu_imm_sequencer_if.sv
// Bus between top-level control/datapath and the immediate-ALU sequencer.
// master: drives start, ir, mem_ready and observes all control outputs.
// slave : the sequencer; samples the requests and drives the controls.
interface alu_imm_sequencer_if #(
    parameter int unsigned IR_W = 32
);
    logic            start;
    logic [IR_W-1:0] ir;
    logic            mem_ready;

    logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin;
    logic Yin, IncPC, Read, Gra, Grb, Rin, Rout, Cout;
    logic [2:0] alu_op;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       timeout_err;
    logic [3:0] state;

    modport master (
        output start, ir, mem_ready,
        input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
        input  Yin, IncPC, Read, Gra, Grb, Rin, Rout, Cout,
        input  alu_op, busy, done, illegal, timeout_err, state
    );

    modport slave (
        input  start, ir, mem_ready,
        output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
        output Yin, IncPC, Read, Gra, Grb, Rin, Rout, Cout,
        output alu_op, busy, done, illegal, timeout_err, state
    );
endinterface

// File: rtl/imm_op_decode.sv
// Combinational opcode decoder for immediate-format ALU instructions.
// Ports: opcode (in)      - instruction opcode field
//        alu_onehot (out) - one-hot ALU select ([0]=ADD, [1]=AND, [2]=OR)
//        legal (out)      - opcode is addi, andi or ori
module imm_op_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [2:0]       alu_onehot,
    output logic             legal
);

    always_comb begin
        alu_onehot = '0;
        legal      = 1'b0;
        if (opcode == OPC_W'(OPC_ADDI)) begin
            alu_onehot[ALU_ADD] = 1'b1;
            legal               = 1'b1;
        end else if (opcode == OPC_W'(OPC_ANDI)) begin
            alu_onehot[ALU_AND] = 1'b1;
            legal               = 1'b1;
        end else if (opcode == OPC_W'(OPC_ORI)) begin
            alu_onehot[ALU_OR] = 1'b1;
            legal              = 1'b1;
        end
    end

endmodule

// File: rtl/alu_imm_sequencer.sv
// Control-step sequencer for addi/andi/ori: fetch (T0-T2, with memory wait
// state T1W and timeout) then execute (T3-T5). Moore outputs decoded from the
// registered state; illegal/timeout_err and the T3 operand controls also look
// at the current ir/mem_ready since they report a decision made in that cycle.
// Ports: Clock, Clear (sync active-low reset), bus (slave side of
//        alu_imm_sequencer_if: start/ir/mem_ready in, datapath controls,
//        alu_op, busy, done, illegal, timeout_err, state out).
module alu_imm_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned IR_W    = 32,
    parameter int unsigned OPC_W   = 5,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input logic                Clock,
    input logic                Clear,
    alu_imm_sequencer_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    logic [OPC_W-1:0] opcode;
    logic [2:0]       dec_onehot;
    logic             dec_legal;
    logic             unused_ir_bits;

    dp_ctrl_t   ctrl;
    logic [2:0] alu_op;
    logic       busy, done, illegal, timeout_err;

    assign opcode         = bus.ir[IR_W-1 -: OPC_W];
    assign unused_ir_bits = ^bus.ir[IR_W-OPC_W-1:0];

    imm_op_decode #(.OPC_W(OPC_W)) u_dec (
        .opcode     (opcode),
        .alu_onehot (dec_onehot),
        .legal      (dec_legal)
    );

    // State, wait counter and latched ALU op
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Next state and per-state control decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        ctrl        = '0;
        alu_op      = '0;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        illegal     = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_T0;
            end
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
                state_d     = S_T1;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_T2;
                end else begin
                    state_d = S_T1W;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_T1W: begin
                // PC already updated in T1; only keep the read going
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_T2;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                state_d      = S_T3;
            end
            S_T3: begin
                if (dec_legal) begin
                    ctrl.grb   = 1'b1;
                    ctrl.r_out = 1'b1;
                    ctrl.y_in  = 1'b1;
                    op_d       = dec_onehot;
                    state_d    = S_T4;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_T4: begin
                // Latched op keeps T4 immune to later ir changes
                ctrl.c_out = 1'b1;
                ctrl.z_in  = 1'b1;
                alu_op     = op_q;
                state_d    = S_T5;
            end
            S_T5: begin
                ctrl.zlow_out = 1'b1;
                ctrl.gra      = 1'b1;
                ctrl.r_in     = 1'b1;
                done          = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.PCout       = ctrl.pc_out;
    assign bus.Zlowout     = ctrl.zlow_out;
    assign bus.MDRout      = ctrl.mdr_out;
    assign bus.MARin       = ctrl.mar_in;
    assign bus.Zin         = ctrl.z_in;
    assign bus.PCin        = ctrl.pc_in;
    assign bus.MDRin       = ctrl.mdr_in;
    assign bus.IRin        = ctrl.ir_in;
    assign bus.Yin         = ctrl.y_in;
    assign bus.IncPC       = ctrl.inc_pc;
    assign bus.Read        = ctrl.read;
    assign bus.Gra         = ctrl.gra;
    assign bus.Grb         = ctrl.grb;
    assign bus.Rin         = ctrl.r_in;
    assign bus.Rout        = ctrl.r_out;
    assign bus.Cout        = ctrl.c_out;
    assign bus.alu_op      = alu_op;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.illegal     = illegal;
    assign bus.timeout_err = timeout_err;
    assign bus.state       = state_q;

endmodule
